if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Decoupling buffer between the fetch stage and the decode stage. Captures each `{instruction, next_pc}` pair that fetch delivers on a cache hit and queues it in a small synchronous FIFO. Presents the oldest entry to decode with a valid flag, holds it while decode stalls, and discards all contents when a taken branch redirects the PC. Cache misses become bubbles: `id_valid` low, `id_instruction` a NOP.

## Interface
Parameters:
- `DEPTH`, 2: number of queue entries; a power of two, ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `hit`  input  1: fetch delivers a valid instruction this cycle.
- `instruction`  input  32: fetched instruction word.
- `next_pc`  input  32: PC+4 of the fetched instruction.
- `pc_source`  input  1: taken branch or redirect this cycle; flush request.
- `stall`  input  1: decode cannot accept the head entry this cycle.
- `id_valid`  output  1: head entry is valid.
- `id_instruction`  output  32: head instruction; `32'h0000_0000` (NOP) when the buffer is empty.
- `id_next_pc`  output  32: head PC+4; 0 when the buffer is empty.
- `fetch_hold`  output  1: asserted when `count ≥ DEPTH-1`; fetch must not deliver a new hit next cycle.
- `count`  output  $clog2(DEPTH)+1: current occupancy.
- `overflow`  output  1: sticky flag set when an enqueue is attempted while the buffer is full; cleared only by `reset`.

## Operation
- Enqueue condition `enq = hit & ~pc_source & (~full | deq)`. Storage write at `wr_ptr`; `wr_ptr` wraps modulo DEPTH.
- Dequeue condition `deq = id_valid & ~stall & ~pc_source`. Advances `rd_ptr`, which wraps modulo DEPTH.
- Count update: `count` changes by `+enq - deq`. Simultaneous enq and deq leaves `count` unchanged, including when full.
- Full buffer:
  - `hit` with a dequeue in the same cycle: accepted.
  - `hit` with no dequeue: the entry is dropped and `overflow` is set. Storage and pointers are untouched.
- Flush (`pc_source=1`):
  - Next edge sets `count=0` and `wr_ptr=rd_ptr=0`.
  - A `hit` in the same cycle is a wrong-path instruction and is discarded. No overflow is recorded.
  - Flush has priority over `stall`.
- Empty buffer: `id_valid=0`, `id_instruction=0`, `id_next_pc=0`. `stall` is ignored.
- `stall` with a valid head: `id_*` stay stable until the dequeue.
- Priority, highest first: `reset`, `pc_source`, enqueue/dequeue.

## Timing
- Reset values: `count=0`, pointers 0, `id_valid=0`, `id_instruction=0`, `id_next_pc=0`, `fetch_hold=0`, `overflow=0`.
- `reset` asserted mid-operation takes effect at the next edge and discards all entries.
- Enqueue-to-visible latency is 1 cycle. There is no input-to-output bypass.
- `id_*`, `count` and `fetch_hold` are derived from registered state only. There is no combinational path from `hit`, `stall` or `pc_source` to any output.
- Throughput is one instruction per cycle when `stall=0`. Steady-state occupancy is 1 with a hit every cycle.
- After a flush at edge N, the first wrong-path-free entry appears at edge N+2, provided `hit` is asserted in cycle N+1.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR = 32'h0000_0000`
  - `WORD_W = 32`
  - a packed typedef `fetch_entry_t {instruction, next_pc}` (64 bits).
- One sub-module, `sync_fifo`:
  - parameterised on width and DEPTH;
  - ports `push`, `pop`, `clear`, `din`, `dout`, `count`, `full`, `empty`.
- `if_id_buffer` adds around `sync_fifo`: the flush logic, NOP substitution, `fetch_hold` and the `overflow` flag.

## Test plan
- Reset, then `hit=1` for 3 cycles with instructions A, B, C (`next_pc` 4, 8, 12), `stall=0` → `id_instruction` shows A, B, C on consecutive cycles starting one cycle after A; `count` stays 1; `overflow=0`.
- `hit=0` for 2 cycles after one entry → `id_valid=0` and `id_instruction=0` once the entry drains.
- DEPTH=2: enqueue A with `stall=1`, then B → `count=2` and `fetch_hold=1`. Release `stall` → A then B are presented, and `count` returns to 0.
- Full with `stall=1`, then `hit` C → C is dropped, `overflow=1` stays set, A and B are intact. Repeat with `stall=0` in the same cycle → C is accepted and `count` stays 2.
- Two entries queued, `pc_source=1` together with `hit` X → next cycle `count=0` and `id_valid=0`; X never appears. Next `hit` Y → Y appears one cycle later.
- Assert `reset` while full and stalled → next cycle all outputs are at their reset values and the old entries never reappear.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch/decode types and constants.
// Used by the IF/ID decoupling buffer.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] next_pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with clear.
// Head is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; no reset needed, count guards visibility.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; clear beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling buffer.
// Flush on redirect, NOP on empty, sticky overflow.
module if_id_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hit,
  input  logic [31:0]            instruction,
  input  logic [31:0]            next_pc,
  input  logic                   pc_source,
  input  logic                   stall,
  output logic                   id_valid,
  output logic [31:0]            id_instruction,
  output logic [31:0]            id_next_pc,
  output logic                   fetch_hold,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t din;
  fetch_entry_t head;
  logic         full;
  logic         empty;
  logic         enq;
  logic         deq;

  assign din.instruction = instruction;
  assign din.next_pc     = next_pc;

  assign id_valid = ~empty;
  assign deq      = id_valid & ~stall & ~pc_source;
  assign enq      = hit & ~pc_source & (~full | deq);

  assign id_instruction = empty ? NOP_INSTR : head.instruction;
  assign id_next_pc     = empty ? '0 : head.next_pc;
  assign fetch_hold     = (count >= CW'(DEPTH - 1));

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .clear (pc_source),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky record of a hit dropped because the queue stayed full.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (hit && !pc_source && full && !deq) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer.
// Directed scenarios plus random traffic vs a queue model.
module tb_if_id_buffer;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hit;
  logic [31:0] instruction;
  logic [31:0] next_pc;
  logic        pc_source;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_next_pc;
  logic        fetch_hold;
  logic [1:0]  count;
  logic        overflow;

  int n_pass = 0;
  int n_total = 0;

  fetch_entry_t mq[$];
  logic         m_ovf;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .hit            (hit),
    .instruction    (instruction),
    .next_pc        (next_pc),
    .pc_source      (pc_source),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_next_pc     (id_next_pc),
    .fetch_hold     (fetch_hold),
    .count          (count),
    .overflow       (overflow)
  );

  function automatic logic [31:0] m_instr();
    return (mq.size() > 0) ? mq[0].instruction : 32'h0;
  endfunction

  function automatic logic [31:0] m_npc();
    return (mq.size() > 0) ? mq[0].next_pc : 32'h0;
  endfunction

  // One clock with the given inputs; model follows the queue rules.
  task automatic step(input logic rs, input logic h,
                      input logic [31:0] ins, input logic [31:0] np,
                      input logic ps, input logic st);
    fetch_entry_t e;
    bit           v;
    bit           d;
    reset = rs; hit = h; instruction = ins;
    next_pc = np; pc_source = ps; stall = st;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (ps) begin
      mq.delete();
    end else begin
      v = (mq.size() > 0);
      d = v && !st;
      if (h && mq.size() == DEPTH && !d) m_ovf = 1'b1;
      if (d) void'(mq.pop_front());
      if (h && mq.size() < DEPTH) begin
        e.instruction = ins;
        e.next_pc = np;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'hdead_beef, 32'h4, 0, 0);
    n_total++;
    if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid);
    else n_pass++;
    n_total++;
    if (id_instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", id_instruction);
    else n_pass++;
    n_total++;
    if (id_next_pc !== 32'h0) $display("FAIL rst_npc: got %h want 0", id_next_pc);
    else n_pass++;
    n_total++;
    if (count !== 2'd0 || fetch_hold !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_flags: got cnt=%0d hold=%b ovf=%b want 0 0 0", count, fetch_hold, overflow);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'haaaa_0001;
    exp_i[1] = 32'hbbbb_0002;
    exp_i[2] = 32'hcccc_0003;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, exp_i[i], 32'(4 * (i + 1)), 0, 0);
      n_total++;
      if (id_instruction !== exp_i[i] || id_next_pc !== 32'(4 * (i + 1)))
        $display("FAIL stream_head%0d: got %h/%h want %h/%h", i, id_instruction, id_next_pc, exp_i[i], 4 * (i + 1));
      else n_pass++;
      n_total++;
      if (count !== 2'd1 || overflow !== 1'b0 || id_valid !== 1'b1)
        $display("FAIL stream_cnt%0d: got cnt=%0d ovf=%b v=%b want 1 0 1", i, count, overflow, id_valid);
      else n_pass++;
    end
  endtask

  task automatic test_drain();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_total++;
    if (id_valid !== 1'b0 || id_instruction !== 32'h0 || count !== 2'd0)
      $display("FAIL drain: got v=%b i=%h cnt=%0d want 0 0 0", id_valid, id_instruction, count);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1111_0000, 32'h4, 0, 1);
    step(0, 1, 32'h2222_0000, 32'h8, 0, 1);
    n_total++;
    if (count !== 2'd2 || fetch_hold !== 1'b1 || id_instruction !== 32'h1111_0000)
      $display("FAIL full_stall: got cnt=%0d hold=%b i=%h want 2 1 11110000", count, fetch_hold, id_instruction);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
    n_total++;
    if (id_instruction !== 32'h2222_0000 || count !== 2'd1)
      $display("FAIL release_b: got i=%h cnt=%0d want 22220000 1", id_instruction, count);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
    n_total++;
    if (count !== 2'd0 || id_valid !== 1'b0)
      $display("FAIL release_empty: got cnt=%0d v=%b want 0 0", count, id_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1111_0000, 32'h4, 0, 1);
    step(0, 1, 32'h2222_0000, 32'h8, 0, 1);
    step(0, 1, 32'h3333_0000, 32'hc, 0, 1);
    n_total++;
    if (overflow !== 1'b1 || count !== 2'd2 || id_instruction !== 32'h1111_0000)
      $display("FAIL ovf_drop: got ovf=%b cnt=%0d i=%h want 1 2 11110000", overflow, count, id_instruction);
    else n_pass++;
    step(0, 1, 32'h3333_0000, 32'hc, 0, 0);
    n_total++;
    if (overflow !== 1'b1 || count !== 2'd2 || id_instruction !== 32'h2222_0000)
      $display("FAIL ovf_accept: got ovf=%b cnt=%0d i=%h want 1 2 22220000", overflow, count, id_instruction);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
    n_total++;
    if (id_instruction !== 32'h3333_0000 || id_next_pc !== 32'hc)
      $display("FAIL ovf_c: got %h/%h want 33330000/c", id_instruction, id_next_pc);
    else n_pass++;
  endtask

  task automatic test_flush();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1111_0000, 32'h4, 0, 1);
    step(0, 1, 32'h2222_0000, 32'h8, 0, 1);
    step(0, 1, 32'h5555_aaaa, 32'h100, 1, 1);
    n_total++;
    if (count !== 2'd0 || id_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL flush: got cnt=%0d v=%b ovf=%b want 0 0 0", count, id_valid, overflow);
    else n_pass++;
    step(0, 1, 32'h7777_0000, 32'h204, 0, 0);
    n_total++;
    if (id_instruction !== 32'h7777_0000 || count !== 2'd1)
      $display("FAIL flush_y: got i=%h cnt=%0d want 77770000 1", id_instruction, count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1111_0000, 32'h4, 0, 1);
    step(0, 1, 32'h2222_0000, 32'h8, 0, 1);
    step(0, 1, 32'h3333_0000, 32'hc, 0, 1);
    step(1, 1, 32'h4444_0000, 32'h10, 0, 1);
    n_total++;
    if (count !== 2'd0 || id_valid !== 1'b0 || overflow !== 1'b0 || fetch_hold !== 1'b0)
      $display("FAIL rst_mid: got cnt=%0d v=%b ovf=%b hold=%b want 0", count, id_valid, overflow, fetch_hold);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
    n_total++;
    if (id_valid !== 1'b0 || id_instruction !== 32'h0)
      $display("FAIL rst_mid_stale: got v=%b i=%h want 0 0", id_valid, id_instruction);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        rs, h, ps, st;
    logic [31:0] ins;
    int          errs;
    step(1, 0, 0, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 49) == 0);
      h = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 2) == 0);
      ins = $urandom;
      step(rs, h, ins, ins ^ 32'h5a5a_0004, ps, st);
      n_total++;
      if (id_valid !== (mq.size() > 0) || id_instruction !== m_instr() ||
          id_next_pc !== m_npc() || count !== 2'(mq.size()) ||
          fetch_hold !== (mq.size() >= DEPTH - 1) || overflow !== m_ovf) begin
        if (errs < 10)
          $display("FAIL rand%0d: got v=%b i=%h n=%h c=%0d h=%b o=%b want v=%b i=%h n=%h c=%0d o=%b",
                   i, id_valid, id_instruction, id_next_pc, count, fetch_hold, overflow,
                   mq.size() > 0, m_instr(), m_npc(), mq.size(), m_ovf);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    m_ovf = 1'b0;
    reset = 1'b1; hit = 1'b0; instruction = '0;
    next_pc = '0; pc_source = 1'b0; stall = 1'b0;
    test_reset();
    test_stream();
    test_drain();
    test_full_stall();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
